// File: rtl/tt_input_debounce_pkg.sv
// Shared constants for the ui_in input-conditioning block.
// Holds the default geometry and the depth of the per-bit synchroniser.
// The debounce top, its per-bit slice and its bus interface import it.
package tt_debounce_pkg;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_CNT_W           = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int SYNC_STAGES         = 2;

endpackage

// File: rtl/tt_input_debounce_if.sv
// Bus bundle between the switch-bank conditioning stage and its neighbours.
//   ena     : count enable; low freezes the debounce counters
//   din     : raw asynchronous switch inputs
//   dout    : debounced levels
//   rise    : one-cycle pulse per bit on a 0->1 change of dout
//   fall    : one-cycle pulse per bit on a 1->0 change of dout
//   changed : registered OR of all rise/fall bits
// The master drives ena/din and observes the results.
// The slave is the debounce block itself.
interface tt_input_debounce_if
  import tt_debounce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             ena;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output ena, din,
    input  dout, rise, fall, changed
  );

  modport slave (
    input  ena, din,
    output dout, rise, fall, changed
  );
endinterface

// File: rtl/tt_input_debounce_bit.sv
// One bit of the switch debouncer.
// Contains the synchroniser chain, the stability counter, the accepted
// level and the registered rise/fall strobes.
//   clk       : system clock
//   rst       : asynchronous active-high reset, clears every flop
//   ena_i     : count enable
//   din_i     : raw pad input
//   dout_o    : debounced level
//   rise_o    : one-cycle pulse when dout_o goes 0->1
//   fall_o    : one-cycle pulse when dout_o goes 1->0
//   accept_o  : combinational "level accepted this cycle".
//               The parent uses it to register its changed flag in step
//               with the strobes.
module tt_debounce_bit
  import tt_debounce_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // The synchroniser always runs; ena only gates the stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  // Any return to the accepted level aborts the count.
  // This means a bounce shorter than DEBOUNCE_CYCLES never gets through.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == dout_q) begin
      cnt_d = '0;
    end else if (ena_i) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout_o   = dout_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = rise_d | fall_d;

endmodule

// File: rtl/tt_input_debounce.sv
// Input conditioning stage for the ui_in switch bank.
// Each bit is synchronised and debounced independently by tt_debounce_bit.
// This level adds only the registered "any bit changed" flag.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : tt_input_debounce_if slave.
//         Inputs ena/din; outputs dout/rise/fall/changed.
module tt_input_debounce
  import tt_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  tt_input_debounce_if.slave  bus
);

  // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("tt_input_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  logic [WIDTH-1:0] dout_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] accept_w;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tt_debounce_bit #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (bus.ena),
      .din_i    (bus.din[i]),
      .dout_o   (dout_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i]),
      .accept_o (accept_w[i])
    );
  end

  // Built from next-state strobes so the flag lands on the strobe cycle.
  always_comb begin
    changed_d = |accept_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign bus.dout    = dout_w;
  assign bus.rise    = rise_w;
  assign bus.fall    = fall_w;
  assign bus.changed = changed_q;

endmodule
